// File: rtl/rpsc_pkg.sv
// Shared types and helpers for the RPSC operator annunciator.
// Channel count, alarm-sequence states and first-out encoding.
package rpsc_pkg;

    localparam int NUM_CH = 7;

    typedef enum logic [1:0] {
        NORM      = 2'd0,
        ALM_UNACK = 2'd1,
        ALM_ACK   = 2'd2,
        RTN_UNACK = 2'd3
    } ann_state_t;

    localparam logic [2:0] FO_NONE = 3'd0;

    // Lowest set bit wins; result is 1-based channel code.
    function automatic logic [2:0] fo_encode(input logic [NUM_CH-1:0] v);
        logic [2:0] code;
        code = FO_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/rpsc_pb_cond.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce,
// accepted level and a one-cycle rising-edge pulse.
module rpsc_pb_cond #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_p
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample matching the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            rise_q  <= level_q & ~prev_q;
        end
    end

    assign level  = level_q;
    assign rise_p = rise_q;

endmodule

// File: rtl/rpsc_annunciator.sv
// Operator annunciator for latched protection outputs FF33-FF39:
// per-channel alarm sequence, flashing lamps, horn and first-out.
import rpsc_pkg::*;

module rpsc_annunciator #(
    parameter int FAST_DIV     = 25_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] la_in,
    input  logic       ack_pb,
    input  logic       rst_pb,
    input  logic       test_pb,
    output logic [6:0] lamp,
    output logic       horn,
    output logic [2:0] first_out
);

    localparam int PW = $clog2(FAST_DIV + 1);
    localparam logic [PW-1:0] PSC_LAST = PW'(FAST_DIV - 1);

    logic [NUM_CH-1:0] la_q;
    logic              ack_p;
    logic              rst_p;
    logic              test_l;
    logic              ack_lvl_unused;
    logic              rst_lvl_unused;
    logic              test_rise_unused;

    logic [PW-1:0]     psc_q;
    logic [PW-1:0]     psc_d;
    logic              fast_q;
    logic              fast_d;
    logic              slow_q;
    logic              slow_d;
    logic [1:0]        tog_q;
    logic [1:0]        tog_d;

    logic [NUM_CH-1:0] norm_q;
    logic [NUM_CH-1:0] norm_d;
    logic [NUM_CH-1:0] unack_d;
    logic [NUM_CH-1:0] lamp_ch_d;
    logic [NUM_CH-1:0] enter;

    logic [6:0]        lamp_q;
    logic [6:0]        lamp_d;
    logic              horn_q;
    logic              horn_d;
    logic [2:0]        fo_q;
    logic [2:0]        fo_d;

    rpsc_pb_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ack (
        .clk    (clk),
        .reset  (reset),
        .raw    (ack_pb),
        .level  (ack_lvl_unused),
        .rise_p (ack_p)
    );

    rpsc_pb_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rst (
        .clk    (clk),
        .reset  (reset),
        .raw    (rst_pb),
        .level  (rst_lvl_unused),
        .rise_p (rst_p)
    );

    rpsc_pb_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_test (
        .clk    (clk),
        .reset  (reset),
        .raw    (test_pb),
        .level  (test_l),
        .rise_p (test_rise_unused)
    );

    // Slow phase toggles on every fourth fast toggle.
    always_comb begin
        psc_d  = psc_q + 1'b1;
        fast_d = fast_q;
        slow_d = slow_q;
        tog_d  = tog_q;
        if (psc_q == PSC_LAST) begin
            psc_d  = '0;
            fast_d = ~fast_q;
            tog_d  = tog_q + 2'd1;
            if (tog_q == 2'd3) begin
                slow_d = ~slow_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ann_state_t st_q;
        ann_state_t st_d;

        // Return to normal only while the latch is clear.
        always_comb begin
            st_d = st_q;
            unique case (st_q)
                NORM: begin
                    if (la_q[g]) st_d = ALM_UNACK;
                end
                ALM_UNACK: begin
                    if (ack_p) st_d = la_q[g] ? ALM_ACK : RTN_UNACK;
                end
                ALM_ACK: begin
                    if (!la_q[g]) st_d = RTN_UNACK;
                end
                RTN_UNACK: begin
                    if (la_q[g]) begin
                        st_d = ALM_UNACK;
                    end else if (rst_p) begin
                        st_d = NORM;
                    end
                end
                default: st_d = NORM;
            endcase
        end

        always_comb begin
            lamp_ch_d[g] = 1'b0;
            unique case (st_d)
                NORM:      lamp_ch_d[g] = 1'b0;
                ALM_UNACK: lamp_ch_d[g] = fast_d;
                ALM_ACK:   lamp_ch_d[g] = 1'b1;
                RTN_UNACK: lamp_ch_d[g] = slow_d;
                default:   lamp_ch_d[g] = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st_q <= NORM;
            end else begin
                st_q <= st_d;
            end
        end

        assign norm_q[g]  = (st_q == NORM);
        assign norm_d[g]  = (st_d == NORM);
        assign unack_d[g] = (st_d == ALM_UNACK);
    end

    assign enter = norm_q & unack_d;

    // First-out is latched once and held until all channels are normal.
    always_comb begin
        fo_d = fo_q;
        if (&norm_d) begin
            fo_d = FO_NONE;
        end else if ((fo_q == FO_NONE) && (|enter)) begin
            fo_d = fo_encode(enter);
        end
    end

    assign horn_d = |unack_d;
    assign lamp_d = test_l ? 7'h7F : lamp_ch_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            la_q   <= '0;
            psc_q  <= '0;
            fast_q <= 1'b0;
            slow_q <= 1'b0;
            tog_q  <= 2'd0;
            lamp_q <= '0;
            horn_q <= 1'b0;
            fo_q   <= FO_NONE;
        end else begin
            la_q   <= la_in;
            psc_q  <= psc_d;
            fast_q <= fast_d;
            slow_q <= slow_d;
            tog_q  <= tog_d;
            lamp_q <= lamp_d;
            horn_q <= horn_d;
            fo_q   <= fo_d;
        end
    end

    assign lamp      = lamp_q;
    assign horn      = horn_q;
    assign first_out = fo_q;

endmodule
